// File: rtl/serial_arith_pkg.sv
// Shared definitions for the bit-serial arithmetic blocks: FSM encoding,
// default operand width and a counter-width helper.
package serial_arith_pkg;

    localparam int DEFAULT_WIDTH = 4;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    // Bits needed to count 0..value-1; never less than one bit.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/serial_subtractor_if.sv
// Start/done request bus of the serial subtractor. The requester owns start/a/b;
// the subtractor owns busy/done and the result fields.
//
// Handshake: a request is taken on a rising clk edge where start=1 and busy=0.
// done pulses for one cycle when difference/carryout/overflow are fresh; the
// result fields otherwise hold the previous completion.
interface serial_subtractor_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] difference;
    logic             carryout;
    logic             overflow;

    modport master (
        output start, a, b,
        input  busy, done, difference, carryout, overflow
    );

    modport slave (
        input  start, a, b,
        output busy, done, difference, carryout, overflow
    );
endinterface

// File: rtl/serial_subtractor_full_adder_cell.sv
// Combinational 1-bit full adder; the serial subtractor reuses one instance
// every cycle.
module full_adder_cell (
    input  logic i_a,
    input  logic i_b,
    input  logic i_cin,
    output logic o_sum,
    output logic o_cout
);
    assign o_sum  = i_a ^ i_b ^ i_cin;
    assign o_cout = (i_a & i_b) | (i_a & i_cin) | (i_b & i_cin);
endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: a - b computed as a + ~b + 1, one bit
// per clock LSB first, with registered result, carryout and overflow.
module serial_subtractor
    import serial_arith_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                clk,
    input  logic                reset,
    serial_subtractor_if.slave  bus,
    output logic [1:0]          o_dbg_state
);
    localparam int             CW   = clog2(WIDTH);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_a_sr;
    logic [WIDTH-1:0] r_b_sr;
    logic [WIDTH-1:0] r_res;
    logic [CW-1:0]    r_cnt;
    logic             r_carry;
    logic [WIDTH-1:0] r_diff;
    logic             r_cout;
    logic             r_ovf;

    logic             w_accept;
    logic             w_sum;
    logic             w_cout;

    // Subtrahend bit is inverted here so the cell stays a plain adder.
    full_adder_cell u_fa (
        .i_a    (r_a_sr[0]),
        .i_b    (~r_b_sr[0]),
        .i_cin  (r_carry),
        .o_sum  (w_sum),
        .o_cout (w_cout)
    );

    assign w_accept = bus.start && ((r_state == IDLE) || (r_state == DONE));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_a_sr  <= '0;
            r_b_sr  <= '0;
            r_res   <= '0;
            r_cnt   <= '0;
            r_carry <= 1'b0;
            r_diff  <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            case (r_state)
                RUN: begin
                    r_res   <= {w_sum, r_res[WIDTH-1:1]};
                    r_carry <= w_cout;
                    r_a_sr  <= r_a_sr >> 1;
                    r_b_sr  <= r_b_sr >> 1;
                    r_cnt   <= r_cnt + CW'(1);
                    // On the MSB step r_carry is still the carry into the MSB.
                    if (r_cnt == LAST) begin
                        r_diff  <= {w_sum, r_res[WIDTH-1:1]};
                        r_cout  <= w_cout;
                        r_ovf   <= r_carry ^ w_cout;
                        r_state <= DONE;
                    end
                end
                default: begin
                    if (w_accept) begin
                        r_a_sr  <= bus.a;
                        r_b_sr  <= bus.b;
                        r_carry <= 1'b1;
                        r_cnt   <= '0;
                        r_state <= RUN;
                    end else begin
                        r_state <= IDLE;
                    end
                end
            endcase
        end
    end

    assign bus.busy       = (r_state == RUN);
    assign bus.done       = (r_state == DONE);
    assign bus.difference = r_diff;
    assign bus.carryout   = r_cout;
    assign bus.overflow   = r_ovf;
    assign o_dbg_state    = r_state;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and randomized bench for serial_subtractor at WIDTH=4 and WIDTH=8,
// checked against an arithmetic model of a - b.
module tb_serial_subtractor;
    import serial_arith_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    serial_subtractor_if #(.WIDTH(4)) bus4 ();
    serial_subtractor_if #(.WIDTH(8)) bus8 ();
    logic [1:0] st4;
    logic [1:0] st8;

    serial_subtractor #(.WIDTH(4)) dut4 (.clk(clk), .reset(reset), .bus(bus4), .o_dbg_state(st4));
    serial_subtractor #(.WIDTH(8)) dut8 (.clk(clk), .reset(reset), .bus(bus8), .o_dbg_state(st8));

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain modular subtraction; flags from the sum a + ~b + 1.
    task automatic ref_sub(input int w, input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] d, output logic co, output logic ov);
        logic [31:0] mask;
        logic [32:0] full;
        mask = (32'd1 << w) - 32'd1;
        a    = a & mask;
        b    = b & mask;
        full = {1'b0, a} + {1'b0, (~b) & mask} + 33'd1;
        d    = full[31:0] & mask;
        co   = full[w];
        ov   = (a[w-1] != b[w-1]) && (d[w-1] != a[w-1]);
    endtask

    function automatic logic [31:0] get_diff(input bit w8);
        return w8 ? 32'(bus8.difference) : 32'(bus4.difference);
    endfunction
    function automatic logic get_busy(input bit w8);
        return w8 ? bus8.busy : bus4.busy;
    endfunction
    function automatic logic get_done(input bit w8);
        return w8 ? bus8.done : bus4.done;
    endfunction
    function automatic logic get_cout(input bit w8);
        return w8 ? bus8.carryout : bus4.carryout;
    endfunction
    function automatic logic get_ovf(input bit w8);
        return w8 ? bus8.overflow : bus4.overflow;
    endfunction

    task automatic set_in(input bit w8, input logic s, input logic [31:0] a, input logic [31:0] b);
        if (w8) begin
            bus8.start = s; bus8.a = a[7:0]; bus8.b = b[7:0];
        end else begin
            bus4.start = s; bus4.a = a[3:0]; bus4.b = b[3:0];
        end
    endtask

    // One full request: pulse start, scramble operands after acceptance,
    // then check latency, busy length, result hold and final values.
    task automatic do_op(input bit w8, input logic [31:0] a, input logic [31:0] b, input string tag);
        int          w;
        int          lat;
        int          busy_cnt;
        bit          got;
        bit          hold_ok;
        logic [31:0] prev;
        logic [31:0] ed;
        logic        eco;
        logic        eov;
        w = w8 ? 8 : 4;
        ref_sub(w, a, b, ed, eco, eov);
        @(negedge clk);
        set_in(w8, 1'b1, a, b);
        @(negedge clk);
        set_in(w8, 1'b0, $urandom, $urandom);
        busy_cnt = int'(get_busy(w8));
        prev     = get_diff(w8);
        hold_ok  = 1'b1;
        got      = 1'b0;
        lat      = 0;
        for (int c = 1; c <= w + 4; c++) begin
            @(negedge clk);
            if (get_done(w8)) begin
                lat = c;
                got = 1'b1;
                break;
            end
            busy_cnt += int'(get_busy(w8));
            if (get_diff(w8) !== prev) hold_ok = 1'b0;
        end
        check({tag, "_latency"}, got ? lat : -1, w);
        check({tag, "_busy_cycles"}, busy_cnt, w);
        check({tag, "_hold"}, 32'(hold_ok), 32'd1);
        check({tag, "_diff"}, get_diff(w8), ed);
        check({tag, "_cout"}, 32'(get_cout(w8)), 32'(eco));
        check({tag, "_ovf"}, 32'(get_ovf(w8)), 32'(eov));
        @(negedge clk);
        check({tag, "_done_pulse"}, {get_done(w8), get_busy(w8)}, 2'b00);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_st4"}, st4, IDLE);
        check({tag, "_st8"}, st8, IDLE);
        check({tag, "_flags4"}, {bus4.busy, bus4.done, bus4.carryout, bus4.overflow}, 4'b0);
        check({tag, "_diff4"}, bus4.difference, 4'h0);
        check({tag, "_flags8"}, {bus8.busy, bus8.done, bus8.carryout, bus8.overflow}, 4'b0);
        check({tag, "_diff8"}, bus8.difference, 8'h00);
    endtask

    initial begin
        reset = 1'b1;
        set_in(1'b0, 1'b0, 0, 0);
        set_in(1'b1, 1'b0, 0, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_state("reset");
        reset = 1'b0;

        // Directed cases
        do_op(1'b0, 32'h6, 32'h2, "sub_6_2");
        do_op(1'b0, 32'h2, 32'h5, "sub_2_5");
        do_op(1'b0, 32'h0, 32'h0, "sub_0_0");
        do_op(1'b0, 32'h5, 32'hC, "ovf_pos");
        do_op(1'b0, 32'h8, 32'h1, "ovf_neg");

        // Start while busy is ignored; start during DONE is taken at once
        @(negedge clk);
        bus4.start = 1'b1; bus4.a = 4'h6; bus4.b = 4'h2;
        @(negedge clk);
        bus4.start = 1'b0;
        @(negedge clk);
        bus4.start = 1'b1; bus4.a = 4'hF; bus4.b = 4'hF;
        @(negedge clk);
        bus4.start = 1'b0;
        repeat (2) @(negedge clk);
        check("b2b_first_done", bus4.done, 1'b1);
        check("b2b_first_res", {bus4.difference, bus4.carryout, bus4.overflow}, {4'h4, 1'b1, 1'b0});
        bus4.start = 1'b1; bus4.a = 4'h3; bus4.b = 4'h1;
        @(negedge clk);
        bus4.start = 1'b0;
        check("b2b_no_gap_busy", bus4.busy, 1'b1);
        repeat (4) @(negedge clk);
        check("b2b_second_done", bus4.done, 1'b1);
        check("b2b_second_res", {bus4.difference, bus4.carryout, bus4.overflow}, {4'h2, 1'b1, 1'b0});
        @(negedge clk);

        // Reset in the middle of a subtraction
        bus4.start = 1'b1; bus4.a = 4'h5; bus4.b = 4'hC;
        @(negedge clk);
        bus4.start = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_reset_state("mid_reset");
        do_op(1'b0, 32'h6, 32'h2, "after_reset");

        // Exhaustive WIDTH=4 sweep
        for (int i = 0; i < 256; i++) begin
            do_op(1'b0, 32'(i >> 4), 32'(i & 15), "sweep4");
        end

        // WIDTH=8 boundary and random operands
        do_op(1'b1, 32'h80, 32'h01, "w8_80_01");
        do_op(1'b1, 32'h7F, 32'hFF, "w8_7f_ff");
        do_op(1'b1, 32'h00, 32'hFF, "w8_00_ff");
        for (int i = 0; i < 40; i++) begin
            do_op(1'b1, $urandom_range(0, 255), $urandom_range(0, 255), "rand8");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
